// File: rtl/mram_ctrl_pkg.sv
// Shared types and constants for the MRAM bus controller: state encoding,
// default bus timing and bus widths.
package mram_ctrl_pkg;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int TIMER_W  = 8;

  localparam int DEF_T_AS = 1;
  localparam int DEF_T_WP = 4;
  localparam int DEF_T_WH = 1;
  localparam int DEF_T_RD = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_PULSE,
    WR_HOLD,
    WAIT_WDATA,
    RD_ACCESS,
    RD_GAP
  } state_t;

  // A command with no byte lanes selected means both lanes.
  function automatic logic [1:0] eff_be(input logic [1:0] be);
    return (be == 2'b00) ? 2'b11 : be;
  endfunction

endpackage

// File: rtl/mram_phase_timer.sv
// Loadable down-counter shared by every timed bus phase; done is high on the
// last cycle of the phase (load with length-1 on phase entry).
module mram_phase_timer
  import mram_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         FPGA_clk,
  input  logic         FPGA_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/mram_bus_ctrl.sv
// Turns decoded read/write burst commands into asynchronous MRAM bus cycles.
// All bus outputs are registered from the next-state decode.
module mram_bus_ctrl
  import mram_ctrl_pkg::*;
#(
  parameter int T_AS = DEF_T_AS,
  parameter int T_WP = DEF_T_WP,
  parameter int T_WH = DEF_T_WH,
  parameter int T_RD = DEF_T_RD
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_be,
  input  logic [2:0]        cmd_burst_len,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_to_MRAM,
  output logic [DATA_W-1:0] data_to_MRAM,
  input  logic [DATA_W-1:0] data_from_MRAM,
  output logic              data_oe,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                write_reg, write_next;
  logic [1:0]          be_reg, be_next;
  logic [2:0]          len_reg, len_next;
  logic [2:0]          beat_reg, beat_next;
  logic                last_beat;
  logic                phase_done;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_val;

  assign last_beat = (beat_reg == len_reg);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    write_next = write_reg;
    be_next    = be_reg;
    len_next   = len_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next = SETUP;
          addr_next  = cmd_addr;
          write_next = cmd_write;
          be_next    = eff_be(cmd_be);
          len_next   = cmd_burst_len;
          beat_next  = 3'd0;
          if (cmd_write) wdata_next = cmd_wdata;
        end
      end
      SETUP:     if (phase_done) state_next = write_reg ? WR_PULSE : RD_ACCESS;
      WR_PULSE:  if (phase_done) state_next = WR_HOLD;
      WR_HOLD:   if (phase_done) state_next = last_beat ? IDLE : WAIT_WDATA;
      WAIT_WDATA: begin
        if (wr_data_valid) begin
          state_next = SETUP;
          wdata_next = wr_data;
          addr_next  = addr_reg + 20'd1;
          beat_next  = beat_reg + 3'd1;
        end
      end
      RD_ACCESS: if (phase_done) state_next = RD_GAP;
      RD_GAP: begin
        if (last_beat) begin
          state_next = IDLE;
        end else begin
          state_next = SETUP;
          addr_next  = addr_reg + 20'd1;
          beat_next  = beat_reg + 3'd1;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // Every phase change reloads the timer with the new phase length.
  always_comb begin
    timer_load = (state_next != state_reg);
    case (state_next)
      SETUP:     timer_val = TIMER_W'(T_AS - 1);
      WR_PULSE:  timer_val = TIMER_W'(T_WP - 1);
      WR_HOLD:   timer_val = TIMER_W'(T_WH - 1);
      RD_ACCESS: timer_val = TIMER_W'(T_RD - 1);
      default:   timer_val = '0;
    endcase
  end

  mram_phase_timer #(.W(TIMER_W)) u_phase_timer (
    .FPGA_clk (FPGA_clk),
    .FPGA_rst (FPGA_rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (phase_done)
  );

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      write_reg     <= 1'b0;
      be_reg        <= 2'b00;
      len_reg       <= 3'd0;
      beat_reg      <= 3'd0;
      cmd_ready     <= 1'b1;
      wr_data_ready <= 1'b0;
      busy          <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      data_oe       <= 1'b0;
      chip_en       <= 1'b1;
      write_en      <= 1'b1;
      out_en        <= 1'b1;
      lower_byte_en <= 1'b1;
      upper_byte_en <= 1'b1;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      write_reg     <= write_next;
      be_reg        <= be_next;
      len_reg       <= len_next;
      beat_reg      <= beat_next;
      cmd_ready     <= (state_next == IDLE);
      wr_data_ready <= (state_next == WAIT_WDATA);
      busy          <= (state_next != IDLE);
      rd_valid      <= (state_next == RD_GAP);
      data_oe       <= (state_next != IDLE) && write_next;
      chip_en       <= (state_next == IDLE);
      write_en      <= (state_next != WR_PULSE);
      out_en        <= (state_next != RD_ACCESS);
      lower_byte_en <= (state_next == IDLE) || !be_next[0];
      upper_byte_en <= (state_next == IDLE) || !be_next[1];
      if (state_reg == RD_ACCESS && phase_done) begin
        rd_data <= data_from_MRAM & {{8{be_reg[1]}}, {8{be_reg[0]}}};
      end
    end
  end

  assign addr_to_MRAM = addr_reg;
  assign data_to_MRAM = wdata_reg;

endmodule

// File: tb/tb_mram_bus_ctrl.sv
// Scoreboard bench for mram_bus_ctrl: the driver queues expected bus writes
// and read responses, a negedge monitor models the MRAM and checks them.
module tb_mram_bus_ctrl;
  import mram_ctrl_pkg::*;

  localparam int T_AS = 1;
  localparam int T_WP = 4;
  localparam int T_WH = 1;
  localparam int T_RD = 4;
  localparam int TMO  = 300;

  logic        FPGA_clk = 1'b0;
  logic        FPGA_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_be;
  logic [2:0]  cmd_burst_len;
  logic        wr_data_valid, wr_data_ready;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, busy;
  logic [19:0] addr_to_MRAM;
  logic [15:0] data_to_MRAM;
  logic [15:0] data_from_MRAM = 16'h0;
  logic        data_oe, chip_en, write_en, out_en, lower_byte_en, upper_byte_en;

  always #5 FPGA_clk = ~FPGA_clk;

  mram_bus_ctrl #(.T_AS(T_AS), .T_WP(T_WP), .T_WH(T_WH), .T_RD(T_RD)) dut (
    .FPGA_clk(FPGA_clk), .FPGA_rst(FPGA_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .cmd_burst_len(cmd_burst_len), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .wr_data(wr_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .addr_to_MRAM(addr_to_MRAM),
    .data_to_MRAM(data_to_MRAM), .data_from_MRAM(data_from_MRAM),
    .data_oe(data_oe), .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
    .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en)
  );

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } beat_t;

  beat_t       wr_q[$];
  beat_t       rd_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] bus_mem[int];
  logic [15:0] cur_wd[8];
  int          checks = 0;
  int          failures = 0;

  function automatic logic [15:0] init_word(input logic [19:0] a);
    return a[15:0] ^ 16'h3C5A ^ {12'h0, a[19:16]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  function automatic logic [15:0] bus_rd(input logic [19:0] a);
    return bus_mem.exists(int'(a)) ? bus_mem[int'(a)] : init_word(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input bit on_wdata, input string name);
    int n = 0;
    while (((on_wdata ? wr_data_ready : cmd_ready) == 1'b0) && n < TMO) begin
      @(posedge FPGA_clk); #1;
      n++;
    end
    if (n >= TMO) check(name, 32'd0, 32'd1);
  endtask

  // Queue the expected outcome of a command, then drive it to completion.
  task automatic send_cmd(input bit wr, input logic [19:0] a, input logic [15:0] d0,
                          input logic [1:0] be, input logic [2:0] len,
                          input int stall_beat, input int stall_cyc);
    logic [1:0]  be_eff;
    logic [19:0] ba;
    logic [15:0] d;
    int          n;
    be_eff = (be == 2'b00) ? 2'b11 : be;
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + 20'(i);
      if (wr) begin
        d = (i == 0) ? d0 : 16'($urandom);
        cur_wd[i] = d;
        wr_q.push_back('{ba, d, be_eff});
        ref_mem[int'(ba)] = merge(ref_rd(ba), d, be_eff);
      end else begin
        d = ref_rd(ba) & {be_eff[1] ? 8'hFF : 8'h00, be_eff[0] ? 8'hFF : 8'h00};
        rd_q.push_back('{ba, d, be_eff});
      end
    end
    cmd_write = wr; cmd_addr = a; cmd_wdata = d0; cmd_be = be; cmd_burst_len = len;
    cmd_valid = 1'b1;
    wait_for(1'b0, "cmd_accept_timeout");
    @(posedge FPGA_clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    if (wr) begin
      for (int b = 1; b <= int'(len); b++) begin
        wait_for(1'b1, "wdata_ready_timeout");
        if (b == stall_beat) begin
          for (int s = 0; s < stall_cyc; s++) begin
            check("stall_chip_en", chip_en, 1'b0);
            @(posedge FPGA_clk); #1;
          end
          check("stall_wr_ready", wr_data_ready, 1'b1);
        end
        wr_data_valid = 1'b1; wr_data = cur_wd[b];
        @(posedge FPGA_clk); #1;
        wr_data_valid = 1'b0;
      end
    end
    while (!cmd_ready && n < TMO) begin
      @(posedge FPGA_clk); #1;
      n++;
    end
    if (!wr) check("rd_burst_cycles", n, (int'(len) + 1) * (T_AS + T_RD + 1));
    else if (len == 0) check("wr_single_cycles", n, T_AS + T_WP + T_WH);
  endtask

  // Bus monitor and MRAM model.
  int          we_cnt = 0, oe_cnt = 0;
  logic        prev_we = 1'b1, prev_oe = 1'b1, prev_rdv = 1'b0;
  logic [19:0] prev_addr = 20'h0, fall_addr = 20'h0;
  logic [15:0] fall_data = 16'h0;
  beat_t       e;

  always @(negedge FPGA_clk) begin
    if (FPGA_rst) begin
      we_cnt = 0; oe_cnt = 0; prev_we = 1'b1; prev_oe = 1'b1; prev_rdv = 1'b0;
      prev_addr = addr_to_MRAM;
      data_from_MRAM = 16'h0;
    end else begin
      if (!write_en || !out_en) check("strobe_exclusive", write_en | out_en, 1'b1);
      if (addr_to_MRAM != prev_addr) check("addr_change_strobes", {write_en, out_en}, 2'b11);
      if (!write_en) begin
        if (prev_we) begin
          check("wr_addr_setup", prev_addr, addr_to_MRAM);
          fall_addr = addr_to_MRAM;
          fall_data = data_to_MRAM;
        end
        we_cnt++;
      end else if (!prev_we) begin
        check("we_width", we_cnt, T_WP);
        check("wr_addr_hold", addr_to_MRAM, fall_addr);
        check("wr_data_hold", data_to_MRAM, fall_data);
        check("wr_oe_ce", {data_oe, chip_en}, 2'b10);
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", addr_to_MRAM, e.addr);
          check("wr_data", data_to_MRAM, e.data);
          check("wr_be", {~upper_byte_en, ~lower_byte_en}, e.be);
        end
        bus_mem[int'(addr_to_MRAM)] = merge(bus_rd(addr_to_MRAM), data_to_MRAM,
                                            {~upper_byte_en, ~lower_byte_en});
        $display("WRITE addr=%05h data=%04h be=%b", addr_to_MRAM, data_to_MRAM,
                 {~upper_byte_en, ~lower_byte_en});
        we_cnt = 0;
      end
      if (!out_en) begin
        oe_cnt++;
        if (rd_q.size() != 0) check("rd_lanes", {~upper_byte_en, ~lower_byte_en}, rd_q[0].be);
        data_from_MRAM = bus_rd(addr_to_MRAM);
      end else begin
        if (!prev_oe) begin
          check("oe_width", oe_cnt, T_RD);
          oe_cnt = 0;
        end
        data_from_MRAM = 16'h0;
      end
      if (rd_valid) begin
        check("rd_valid_pulse", prev_rdv, 1'b0);
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e = rd_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_addr", addr_to_MRAM, e.addr);
        end
        $display("READ  addr=%05h data=%04h", addr_to_MRAM, rd_data);
      end
      prev_we = write_en; prev_oe = out_en; prev_rdv = rd_valid;
      prev_addr = addr_to_MRAM;
    end
  end

  initial begin
    int n;
    logic [2:0]  len;
    logic [19:0] a;
    FPGA_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = 2'b00; cmd_burst_len = 3'd0; wr_data_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge FPGA_clk);
    #1;
    check("rst_strobes", {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, 5'h1F);
    check("rst_addr", addr_to_MRAM, 20'h0);
    check("rst_data", data_to_MRAM, 16'h0);
    check("rst_misc", {data_oe, rd_valid, wr_data_ready, busy, cmd_ready}, 5'b00001);
    check("rst_rd_data", rd_data, 16'h0);
    FPGA_rst = 1'b0;
    @(posedge FPGA_clk); #1;

    send_cmd(1'b1, 20'h55555, 16'h5555, 2'b11, 3'd0, -1, 0);
    ref_mem[0] = 16'hA5C3; bus_mem[0] = 16'hA5C3;
    send_cmd(1'b0, 20'h00000, 16'h0, 2'b11, 3'd0, -1, 0);
    send_cmd(1'b1, 20'hFFFFE, 16'h1357, 2'b11, 3'd3, 2, 3);
    send_cmd(1'b0, 20'hFFFFE, 16'h0, 2'b00, 3'd3, -1, 0);
    ref_mem[20'h12345] = 16'hBEEF; bus_mem[20'h12345] = 16'hBEEF;
    send_cmd(1'b0, 20'h12345, 16'h0, 2'b01, 3'd0, -1, 0);

    // Reset during the third WE-low cycle abandons the write.
    cmd_write = 1'b1; cmd_addr = 20'h00777; cmd_wdata = 16'h1234; cmd_be = 2'b11;
    cmd_burst_len = 3'd0; cmd_valid = 1'b1;
    wait_for(1'b0, "rst_cmd_timeout");
    @(posedge FPGA_clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge FPGA_clk);
    #1;
    check("rst_mid_we_low", write_en, 1'b0);
    FPGA_rst = 1'b1;
    @(posedge FPGA_clk); #1;
    check("rst_mid_strobes", {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, 5'h1F);
    check("rst_mid_ready", {cmd_ready, busy, data_oe}, 3'b100);
    repeat (2) @(posedge FPGA_clk);
    #1;
    FPGA_rst = 1'b0;
    repeat (4) @(posedge FPGA_clk);
    #1;
    check("rst_mid_idle", {chip_en, busy}, 2'b10);

    // cmd_valid held high across a read: second command waits for IDLE.
    rd_q.push_back('{20'h00000, ref_rd(20'h00000), 2'b11});
    rd_q.push_back('{20'h55555, ref_rd(20'h55555), 2'b11});
    cmd_write = 1'b0; cmd_addr = 20'h00000; cmd_be = 2'b11; cmd_burst_len = 3'd0;
    cmd_valid = 1'b1;
    wait_for(1'b0, "held_cmd_timeout");
    @(posedge FPGA_clk); #1;
    cmd_addr = 20'h55555;
    n = 0;
    while (!cmd_ready && n < TMO) begin
      @(posedge FPGA_clk); #1;
      n++;
    end
    check("held_accept_gap", n, T_AS + T_RD + 1);
    @(posedge FPGA_clk); #1;
    cmd_valid = 1'b0;
    check("held_second_busy", busy, 1'b1);
    wait_for(1'b0, "held_done_timeout");

    for (int t = 0; t < 30; t++) begin
      len = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 0) ? 20'hFFFF8 + 20'($urandom_range(0, 7))
                                     : 20'($urandom_range(0, 63));
      send_cmd(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)), len,
               (len == 0) ? -1 : $urandom_range(1, int'(len)), $urandom_range(0, 3));
    end

    repeat (5) @(posedge FPGA_clk);
    #1;
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
